// File: rtl/sys_arr_pkg.sv
// Shared defaults, accumulator width derivation and swap FSM encoding
// for the parametrised weight-stationary systolic array.
package sys_arr_pkg;

    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 4;
    localparam int DEF_DATA_W = 8;

    // Full-precision product plus enough headroom to add ROWS products.
    function automatic int acc_width(input int data_w, input int rows);
        return 2 * data_w + $clog2(rows);
    endfunction

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

endpackage

// File: rtl/sys_arr_pe.sv
// One systolic cell: shadow/active weight pair, signed MAC, registered
// data pass-through to the right and registered partial sum downwards.
module sys_arr_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_shift,
    input  logic                     w_promote,
    input  logic signed [DATA_W-1:0] w_in,
    output logic signed [DATA_W-1:0] w_out,
    input  logic signed [DATA_W-1:0] a_in,
    output logic signed [DATA_W-1:0] a_out,
    input  logic signed [ACC_W-1:0]  s_in,
    output logic signed [ACC_W-1:0]  s_out
);

    logic signed [DATA_W-1:0]   shadow_q, shadow_d;
    logic signed [DATA_W-1:0]   act_q, act_d;
    logic signed [DATA_W-1:0]   a_q, a_d;
    logic signed [ACC_W-1:0]    s_q, s_d;
    logic signed [2*DATA_W-1:0] prod;

    // Next-state: weight shift/promote, and MAC with sign-extended product.
    always_comb begin
        shadow_d = w_shift ? w_in : shadow_q;
        act_d    = w_promote ? shadow_q : act_q;
        prod     = (2*DATA_W)'(a_in) * (2*DATA_W)'(act_q);
        a_d      = a_in;
        s_d      = s_in + ACC_W'(prod);
    end

    // Cell registers; the partial sum wraps modulo 2^ACC_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            act_q    <= '0;
            a_q      <= '0;
            s_q      <= '0;
        end else begin
            shadow_q <= shadow_d;
            act_q    <= act_d;
            a_q      <= a_d;
            s_q      <= s_d;
        end
    end

    assign w_out = shadow_q;
    assign a_out = a_q;
    assign s_out = s_q;

endmodule

// File: rtl/sys_arr_gen.sv
// ROWS x COLS weight-stationary systolic array with input skew, output
// de-skew, valid pipeline, shadow weight loading and a guarded swap.
module sys_arr_gen
    import sys_arr_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = acc_width(DATA_W, ROWS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*DATA_W-1:0]  in_data,
    input  logic                    w_load,
    input  logic [COLS*DATA_W-1:0]  w_data,
    output logic                    w_ready,
    input  logic                    w_swap,
    output logic                    w_full,
    output logic                    swap_err,
    output logic                    out_valid,
    output logic [COLS*ACC_W-1:0]   out_data
);

    localparam int L     = ROWS + COLS - 1;
    localparam int CNT_W = $clog2(ROWS + 1);

    swap_state_e      state_q, state_d;
    logic             swap_err_q, swap_err_d;
    logic [CNT_W-1:0] w_count_q, w_count_d;
    logic [L-1:0]     valid_q, valid_d;
    logic             accept, w_accept, promote, pipe_drained;

    logic signed [DATA_W-1:0] in_feed [ROWS];
    logic signed [DATA_W-1:0] a_h     [ROWS][COLS+1];
    logic signed [ACC_W-1:0]  s_v     [ROWS+1][COLS];
    logic signed [DATA_W-1:0] w_v     [ROWS+1][COLS];
    logic signed [ACC_W-1:0]  col_out [COLS];

    genvar gi, gj;

    assign in_ready = (state_q == IDLE);
    assign w_ready  = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign w_accept = w_load && w_ready;
    assign w_full   = (w_count_q == CNT_W'(ROWS));
    assign swap_err = swap_err_q;
    assign out_valid = valid_q[L-1];

    // Input skew: row gi reaches PE(gi,0) gi cycles after acceptance.
    for (gi = 0; gi < ROWS; gi++) begin : g_skew
        assign in_feed[gi] = accept ? in_data[gi*DATA_W +: DATA_W] : '0;
        if (gi == 0) begin : g_direct
            assign a_h[gi][0] = in_feed[gi];
        end else begin : g_delay
            logic [gi-1:0][DATA_W-1:0] skew_q, skew_d;
            // Shift the row operand one stage per cycle.
            always_comb begin
                skew_d[0] = in_feed[gi];
                for (int k = 1; k < gi; k++) begin
                    skew_d[k] = skew_q[k-1];
                end
            end
            // Skew stage registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    skew_q <= '0;
                end else begin
                    skew_q <= skew_d;
                end
            end
            assign a_h[gi][0] = skew_q[gi-1];
        end
    end

    // Top-row sums start at zero; weight rows enter the shadow chain at row 0.
    for (gj = 0; gj < COLS; gj++) begin : g_top
        assign s_v[0][gj] = '0;
        assign w_v[0][gj] = w_data[gj*DATA_W +: DATA_W];
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_col
            sys_arr_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk       (clk),
                .reset     (reset),
                .w_shift   (w_accept),
                .w_promote (promote),
                .w_in      (w_v[gi][gj]),
                .w_out     (w_v[gi+1][gj]),
                .a_in      (a_h[gi][gj]),
                .a_out     (a_h[gi][gj+1]),
                .s_in      (s_v[gi][gj]),
                .s_out     (s_v[gi+1][gj])
            );
        end
    end

    // Output de-skew: column gj is held COLS-1-gj more cycles so all align.
    for (gj = 0; gj < COLS; gj++) begin : g_deskew
        localparam int D = COLS - 1 - gj;
        if (D == 0) begin : g_direct
            assign col_out[gj] = s_v[ROWS][gj];
        end else begin : g_delay
            logic [D-1:0][ACC_W-1:0] dsk_q, dsk_d;
            // Shift the column sum one stage per cycle.
            always_comb begin
                dsk_d[0] = s_v[ROWS][gj];
                for (int k = 1; k < D; k++) begin
                    dsk_d[k] = dsk_q[k-1];
                end
            end
            // De-skew stage registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dsk_q <= '0;
                end else begin
                    dsk_q <= dsk_d;
                end
            end
            assign col_out[gj] = dsk_q[D-1];
        end
        assign out_data[gj*ACC_W +: ACC_W] = col_out[gj];
    end

    // Valid pipeline. "Drained" means only the oldest slot may still be set:
    // that result leaves this cycle and its last MAC was already done, so
    // the active weights can change on this edge.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = accept;
        for (int k = 1; k < L; k++) begin
            valid_d[k] = valid_q[k-1];
        end
        pipe_drained = 1'b1;
        for (int k = 0; k < L - 1; k++) begin
            if (valid_q[k]) begin
                pipe_drained = 1'b0;
            end
        end
    end

    // Swap FSM next state, error pulse, promotion and shadow row count.
    always_comb begin
        state_d    = state_q;
        swap_err_d = 1'b0;
        promote    = 1'b0;
        w_count_d  = w_count_q;
        case (state_q)
            IDLE: begin
                if (w_swap) begin
                    if (w_full) begin
                        state_d = PENDING;
                    end else begin
                        swap_err_d = 1'b1;
                    end
                end
            end
            PENDING: begin
                if (pipe_drained) begin
                    state_d = IDLE;
                    promote = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (promote) begin
            w_count_d = '0;
        end else if (w_accept && !w_full) begin
            w_count_d = w_count_q + 1'b1;
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            swap_err_q <= 1'b0;
            w_count_q  <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            swap_err_q <= swap_err_d;
            w_count_q  <= w_count_d;
            valid_q    <= valid_d;
        end
    end

    // Right-edge data outputs and bottom shadow outputs have no consumer.
    logic unused_edge;
    always_comb begin
        unused_edge = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            unused_edge = unused_edge ^ (^a_h[r][COLS]);
        end
        for (int c = 0; c < COLS; c++) begin
            unused_edge = unused_edge ^ (^w_v[ROWS][c]);
        end
    end

endmodule
